// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and burst helpers for the layer-1 bus matrix.
package ahb_mtx_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_e;

  localparam int BEAT_W = 4;

  // Remaining beats after the NONSEQ of a fixed-length burst; 0 for SINGLE/INCR.
  function automatic logic [BEAT_W-1:0] burst_beats_m1(input logic [2:0] hburst);
    case (hburst)
      HB_WRAP4,  HB_INCR4:  return BEAT_W'(3);
      HB_WRAP8,  HB_INCR8:  return BEAT_W'(7);
      HB_WRAP16, HB_INCR16: return BEAT_W'(15);
      default:              return '0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Rotated-priority scan: first set req bit starting at rr_ptr, wrapping modulo NUM_PORTS.
module ahb_rr_pick #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    rr_ptr,
  output logic [PORT_W-1:0]    winner,
  output logic                 found
);

  logic [PORT_W-1:0] idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = PORT_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_out_rr_arb.sv
// Output-stage round-robin arbiter for one shared AHB slave port; holds across
// fixed bursts and locks, and bounds undefined-length ownership with a hold limit.
module ahb_out_rr_arb
  import ahb_mtx_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int MAX_HOLD  = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port,
  output logic                 arb_busy
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [PORT_W-1:0]    rr_ptr, winner, rr_nxt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [NUM_PORTS-1:0] owner_mask;
  logic active, other_req, hold_max, found, keep, grant, owner_chg;

  assign active     = HSELM && (HTRANSM != HT_IDLE);
  assign owner_mask = NUM_PORTS'(1) << addr_in_port;
  assign other_req  = |(req_port & ~owner_mask);
  assign hold_max   = (hold_cnt >= HOLD_W'(MAX_HOLD));

  ahb_rr_pick #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) u_pick (
    .req    (req_port),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .found  (found)
  );

  // Lock, in-flight fixed burst, or an active owner under its hold budget keeps the grant.
  assign keep      = HMASTLOCKM
                  || ((beat_cnt != '0) && (HTRANSM == HT_SEQ))
                  || (active && (!other_req || !hold_max));
  assign grant     = !keep && found;
  assign owner_chg = grant && (no_port || (winner != addr_in_port));
  assign rr_nxt    = (winner == PORT_W'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_in_port <= '0;
      no_port      <= 1'b1;
      arb_busy     <= 1'b0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      hold_cnt     <= '0;
    end else if (HREADYM) begin
      if (grant) begin
        addr_in_port <= winner;
        no_port      <= 1'b0;
        rr_ptr       <= rr_nxt;
      end else if (!keep && !HSELM) begin
        no_port      <= 1'b1;
      end

      arb_busy <= HMASTLOCKM | (beat_cnt != '0);

      // A NONSEQ always restarts tracking: reload for fixed bursts, clear otherwise.
      if (active && (HTRANSM == HT_NONSEQ))
        beat_cnt <= burst_beats_m1(HBURSTM);
      else if (active && (HTRANSM == HT_SEQ) && (beat_cnt != '0))
        beat_cnt <= beat_cnt - 1'b1;
      else if (HTRANSM == HT_IDLE)
        beat_cnt <= '0;

      if (owner_chg || !other_req)
        hold_cnt <= '0;
      else if (active && !hold_max)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_out_rr_arb.sv
// Self-checking bench for ahb_out_rr_arb: directed scenarios plus random traffic
// compared against a behavioural arbitration model.
module tb_ahb_out_rr_arb;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int MH = 16;

  localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_WRAP4 = 3'd2,
                         B_INCR4 = 3'd3, B_INCR8 = 3'd5;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [N-1:0]  req_port;
  logic          HREADYM, HSELM, HMASTLOCKM;
  logic [1:0]    HTRANSM;
  logic [2:0]    HBURSTM;
  logic [PW-1:0] addr_in_port;
  logic          no_port, arb_busy;

  int vectors     = 0;
  int miscompares = 0;

  ahb_out_rr_arb #(.NUM_PORTS(N), .PORT_W(PW), .MAX_HOLD(MH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM),
    .HSELM(HSELM), .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
    .addr_in_port(addr_in_port), .no_port(no_port), .arb_busy(arb_busy)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- behavioural reference model ----------------
  int m_owner, m_rr, m_beats, m_hold;
  bit m_nop, m_busy;
  int n_owner, n_rr, n_beats, n_hold, n_w;
  bit n_nop, n_busy, n_act, n_oth, n_keep, n_grant;

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  always_comb begin
    n_act = HSELM && (HTRANSM != T_IDLE);
    n_oth = 1'b0;
    n_w   = -1;
    for (int i = 0; i < N; i++)
      if (req_port[i] === 1'b1 && i != m_owner) n_oth = 1'b1;
    for (int k = 0; k < N; k++)
      if (n_w < 0 && req_port[(m_rr + k) % N] === 1'b1) n_w = (m_rr + k) % N;
    n_keep  = HMASTLOCKM || (m_beats > 0 && HTRANSM == T_SEQ) || (n_act && (!n_oth || m_hold < MH));
    n_grant = !n_keep && (n_w >= 0);
    n_owner = n_grant ? n_w : m_owner;
    n_rr    = n_grant ? (n_w + 1) % N : m_rr;
    n_nop   = n_grant ? 1'b0 : ((!n_keep && !HSELM) ? 1'b1 : m_nop);
    if (n_act && HTRANSM == T_NONSEQ)                 n_beats = burst_len(HBURSTM) - 1;
    else if (n_act && HTRANSM == T_SEQ && m_beats > 0) n_beats = m_beats - 1;
    else if (HTRANSM == T_IDLE)                       n_beats = 0;
    else                                              n_beats = m_beats;
    if ((n_grant && (m_nop || n_w != m_owner)) || !n_oth) n_hold = 0;
    else if (n_act)                                       n_hold = (m_hold + 1 > MH) ? MH : m_hold + 1;
    else                                                  n_hold = m_hold;
    n_busy = HMASTLOCKM || (m_beats > 0);
  end

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_owner <= 0; m_nop <= 1'b1; m_busy <= 1'b0; m_rr <= 0; m_beats <= 0; m_hold <= 0;
    end else if (HREADYM) begin
      m_owner <= n_owner; m_nop <= n_nop; m_busy <= n_busy;
      m_rr <= n_rr; m_beats <= n_beats; m_hold <= n_hold;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [N-1:0] r, input logic rdy, input logic sel,
                       input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    req_port = r; HREADYM = rdy; HSELM = sel; HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
  endtask

  task automatic step;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic apply_reset;
    drive('0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    HRESET = 1'b1;
    @(negedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    apply_reset;
    vectors++;
    if (addr_in_port !== '0 || no_port !== 1'b1 || arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: addr=%0d no_port=%b busy=%b, want addr=0 no_port=1 busy=0",
               addr_in_port, no_port, arb_busy);
    end
    drive(4'b0100, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step;
    drive(4'b0110, 1'b1, 1'b1, T_NONSEQ, B_INCR8, 1'b0); step;
    drive(4'b0110, 1'b1, 1'b1, T_SEQ, B_INCR8, 1'b0); step;
    drive(4'b0110, 1'b1, 1'b1, T_SEQ, B_INCR8, 1'b0); step;
    vectors++;
    if (addr_in_port !== 2'd2 || no_port !== 1'b0 || arb_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_preburst: addr=%0d no_port=%b busy=%b, want addr=2 no_port=0 busy=1",
               addr_in_port, no_port, arb_busy);
    end
    #2 HRESET = 1'b1;
    #1;
    vectors++;
    if (addr_in_port !== '0 || no_port !== 1'b1 || arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: addr=%0d no_port=%b busy=%b, want addr=0 no_port=1 busy=0",
               addr_in_port, no_port, arb_busy);
    end
    drive('0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic test_fairness;
    apply_reset;
    drive(4'b1111, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step;
    for (int g = 0; g < 8; g++) begin
      vectors++;
      if (no_port !== 1'b0 || addr_in_port !== PW'(g % N)) begin
        miscompares++;
        $display("FAIL fairness_grant%0d: owner=%0d no_port=%b, want owner=%0d no_port=0",
                 g, addr_in_port, no_port, g % N);
      end
      drive(4'b1111, 1'b1, 1'b1, T_NONSEQ, B_SINGLE, 1'b0); step;
      drive(4'b1111, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0); step;
    end
  endtask

  task automatic test_fixed_burst;
    logic       rdy_t [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] tr_t  [7] = '{T_NONSEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_SEQ, T_IDLE};
    int         own_t [7] = '{1, 1, 1, 1, 1, 1, 2};
    logic       bsy_t [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset;
    drive(4'b0010, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step;
    for (int s = 0; s < 7; s++) begin
      drive(4'b0110, rdy_t[s], 1'b1, tr_t[s], B_INCR4, 1'b0); step;
      vectors++;
      if (addr_in_port !== PW'(own_t[s]) || no_port !== 1'b0 || arb_busy !== bsy_t[s]) begin
        miscompares++;
        $display("FAIL fixed_burst_step%0d: owner=%0d no_port=%b busy=%b, want owner=%0d no_port=0 busy=%b",
                 s, addr_in_port, no_port, arb_busy, own_t[s], bsy_t[s]);
      end
    end
  endtask

  task automatic test_hold_limit;
    int exp;
    apply_reset;
    drive(4'b0001, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step;
    for (int b = 1; b <= 17; b++) begin
      drive(4'b1001, 1'b1, 1'b1, (b == 1) ? T_NONSEQ : T_SEQ, B_INCR, 1'b0); step;
      exp = (b <= MH) ? 0 : 3;
      vectors++;
      if (addr_in_port !== PW'(exp) || no_port !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_limit_beat%0d: owner=%0d no_port=%b, want owner=%0d no_port=0",
                 b, addr_in_port, no_port, exp);
      end
      if (b == 8) begin
        drive(4'b1001, 1'b0, 1'b1, T_SEQ, B_INCR, 1'b0); step; step;
      end
    end
  endtask

  task automatic test_lock;
    apply_reset;
    drive(4'b0100, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step;
    for (int b = 0; b < 8; b++) begin
      drive(4'b1011, 1'b1, 1'b1, (b % 4 == 0) ? T_NONSEQ : T_SEQ, B_WRAP4, 1'b1); step;
      vectors++;
      if (addr_in_port !== 2'd2 || no_port !== 1'b0 || arb_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL lock_beat%0d: owner=%0d no_port=%b busy=%b, want owner=2 no_port=0 busy=1",
                 b, addr_in_port, no_port, arb_busy);
      end
    end
    drive(4'b1011, 1'b1, 1'b1, T_IDLE, B_SINGLE, 1'b0); step;
    vectors++;
    if (addr_in_port !== 2'd3 || no_port !== 1'b0 || arb_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL lock_release: owner=%0d no_port=%b busy=%b, want owner=3 no_port=0 busy=0",
               addr_in_port, no_port, arb_busy);
    end
  endtask

  task automatic test_early_term;
    logic [1:0] tr_t  [5] = '{T_NONSEQ, T_SEQ, T_SEQ, T_NONSEQ, T_IDLE};
    logic [2:0] bu_t  [5] = '{B_INCR8, B_INCR8, B_INCR8, B_SINGLE, B_SINGLE};
    int         own_t [5] = '{0, 0, 0, 0, 1};
    logic       bsy_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset;
    drive(4'b0001, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0); step;
    for (int s = 0; s < 5; s++) begin
      drive(4'b0011, 1'b1, 1'b1, tr_t[s], bu_t[s], 1'b0); step;
      vectors++;
      if (addr_in_port !== PW'(own_t[s]) || no_port !== 1'b0 || arb_busy !== bsy_t[s]) begin
        miscompares++;
        $display("FAIL early_term_step%0d: owner=%0d no_port=%b busy=%b, want owner=%0d no_port=0 busy=%b",
                 s, addr_in_port, no_port, arb_busy, own_t[s], bsy_t[s]);
      end
    end
  endtask

  task automatic test_random;
    apply_reset;
    for (int c = 0; c < 1500; c++) begin
      drive(N'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
            2'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0));
      step;
      vectors++;
      if (addr_in_port !== PW'(m_owner) || no_port !== m_nop || arb_busy !== m_busy) begin
        miscompares++;
        $display("FAIL random_cycle%0d: owner=%0d no_port=%b busy=%b, want owner=%0d no_port=%b busy=%b",
                 c, addr_in_port, no_port, arb_busy, m_owner, m_nop, m_busy);
      end
    end
  endtask

  initial begin
    HRESET = 1'b1;
    drive('0, 1'b1, 1'b0, T_IDLE, B_SINGLE, 1'b0);
    test_reset;
    test_fairness;
    test_fixed_burst;
    test_hold_limit;
    test_lock;
    test_early_term;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
